store_drain_unit: RTL
=====================

STORE_DRAIN_UNIT -- requirements
Module: store_drain_unit

Interface
REQ-001 SHALL have parameter SDU_DEPTH, 4, drain FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter SDU_TIMEOUT_CYCLES, 64, response watchdog limit (used only with SDU_TIMEOUT_EN).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port issue_vld_i  input  1  committed store presented by store data queue.
REQ-006 SHALL have port issue_entry_i  input  sdq_entry_t  store entry (addr, store_data used).
REQ-007 SHALL have port issue_en_o  output  1  permission for store data queue to issue next cycle.
REQ-008 SHALL have port mem_req_o  output  1  memory write request.
REQ-009 SHALL have port mem_addr_o  output  32  word-aligned write address.
REQ-010 SHALL have port mem_wdata_o  output  32  write data.
REQ-011 SHALL have port mem_gnt_i  input  1  request accepted this cycle.
REQ-012 SHALL have port mem_rsp_vld_i  input  1  write completion.
REQ-013 SHALL have port mem_err_i  input  1  completion carries error; sampled only with mem_rsp_vld_i.
REQ-014 SHALL have port busy_o  output  1  FIFO non-empty or FSM not IDLE.
REQ-015 SHALL have port err_o  output  1  sticky error (bus error, overflow, misalign, timeout).

Function
REQ-016 SHALL push issue_entry_i into FIFO tail on every cycle issue_vld_i=1; store data queue delivers an entry one cycle after sampling issue_en_o=1.
REQ-017 SHALL drive issue_en_o = (registered occupancy <= SDU_DEPTH-2), covering the one-cycle issue latency without overflow.
REQ-018 SHALL, on issue_vld_i with FIFO full, drop the entry and set err_o.
REQ-019 SHALL run FSM IDLE -> REQ when FIFO non-empty; REQ -> WAIT_RSP on mem_gnt_i; WAIT_RSP -> IDLE on mem_rsp_vld_i.
REQ-020 SHALL hold mem_req_o, mem_addr_o, mem_wdata_o stable from FIFO head throughout REQ; mem_req_o=0 in other states.
REQ-021 SHALL pop the head only on the mem_rsp_vld_i cycle; at most one write outstanding.
REQ-022 SHALL accept simultaneous push and pop in one cycle; occupancy unchanged; pointers wrap modulo SDU_DEPTH with an extra wrap bit for full/empty.
REQ-023 SHALL drive mem_addr_o = {addr[31:2],2'b00}; addr[1:0]!=0 sets err_o, write still issued.
REQ-024 SHALL set err_o when mem_rsp_vld_i & mem_err_i; entry still popped, draining continues.
REQ-025 SHALL ignore mem_gnt_i outside REQ and mem_rsp_vld_i outside WAIT_RSP.
REQ-026 SHALL issue drained stores strictly in arrival order.

Reset
REQ-027 SHALL, with rst_i=0 at a clock edge, clear FIFO pointers and occupancy, enter IDLE, clear err_o and the watchdog.
REQ-028 SHALL hold outputs during reset: issue_en_o=0, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, err_o=0.
REQ-029 SHALL abandon any outstanding write on reset mid-transaction; responses after reset are ignored per REQ-025.

Configuration
REQ-030 SHALL, with SDU_TIMEOUT_EN defined, count cycles in WAIT_RSP and at SDU_TIMEOUT_CYCLES without mem_rsp_vld_i set err_o, pop head, return to IDLE.
REQ-031 SHALL, without SDU_TIMEOUT_EN, contain no watchdog counter and wait in WAIT_RSP indefinitely.

Structure
REQ-032 SHALL take sdq_entry_t from the shared memory-system package and add there sdu_state_t (IDLE, REQ, WAIT_RSP) and default SDU_DEPTH / SDU_TIMEOUT_CYCLES constants.
REQ-033 SHALL implement storage in one sub-module sdu_fifo (push, pop, head data, count, full, empty).

Verification
REQ-034 SHALL cover: single store addr=0x100 data=0xDEADBEEF, gnt after 2 cycles, rsp after 3 -> one write 0x100/0xDEADBEEF, err_o=0, busy_o low after rsp.
REQ-035 SHALL cover: issue_vld_i every cycle, mem stalled, SDU_DEPTH=4 -> issue_en_o low at occupancy 3, no entry dropped, four writes in order.
REQ-036 SHALL cover: push and rsp same cycle at occupancy 2 -> occupancy stays 2; 10 stores across pointer wrap drain in order.
REQ-037 SHALL cover: rsp with mem_err_i=1 on first of two stores -> err_o=1 sticky, second store still written.
REQ-038 SHALL cover: rst_i=0 in WAIT_RSP with 3 queued -> next cycle mem_req_o=0, busy_o=0, err_o=0; late rsp ignored.
REQ-039 SHALL cover (SDU_TIMEOUT_EN): no rsp for 64 cycles -> err_o=1, head popped, next store requested.

Source files
------------

// File: rtl/store_drain_unit_pkg.sv
// Shared memory-system package.
// Holds the store data queue entry type consumed by the store drain unit,
// the drain FSM state type and the default drain unit configuration.
// The optional response watchdog is enabled by defining SDU_TIMEOUT_EN.
package store_drain_unit_pkg;

    // Committed store as presented by the store data queue.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] store_data;
    } sdq_entry_t;

    // Drain FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } sdu_state_t;

    localparam int unsigned SDU_DEPTH_DEFAULT          = 4;
    localparam int unsigned SDU_TIMEOUT_CYCLES_DEFAULT = 64;

    // A word write whose byte offset is non-zero is flagged as misaligned.
    function automatic logic sdu_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/sdu_fifo.sv
// Drain FIFO for the store drain unit.
// Ports:
//   clk_i, rst_i   clock, synchronous active-low reset
//   push_i/data_i  write data_i to the tail (ignored when full)
//   pop_i          drop the head entry (ignored when empty)
//   head_o         entry at the head
//   count_o        registered occupancy
//   full_o/empty_o occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sdu_fifo
    import store_drain_unit_pkg::*;
#(
    parameter int unsigned DEPTH = SDU_DEPTH_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  sdq_entry_t                 data_i,
    input  logic                       pop_i,
    output sdq_entry_t                 head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    sdq_entry_t      r_mem [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    assign empty_o   = (r_wr_ptr == r_rd_ptr);
    assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count_o   = r_wr_ptr - r_rd_ptr;
    assign head_o    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/store_drain_unit.sv
// Store drain unit: buffers committed stores from the store data queue and
// writes them to memory one at a time, strictly in arrival order.
// Ports:
//   clk_i, rst_i              clock, synchronous active-low reset
//   issue_vld_i/issue_entry_i store delivered by the store data queue
//   issue_en_o                permission for the queue to issue next cycle
//   mem_req_o/addr/wdata      memory write request, held through REQ
//   mem_gnt_i                 request accepted
//   mem_rsp_vld_i/mem_err_i   write completion and its error flag
//   busy_o                    entries buffered or a write in flight
//   err_o                     sticky: bus error, overflow, misalign, timeout
// Define SDU_TIMEOUT_EN to add a response watchdog of SDU_TIMEOUT_CYCLES.
module store_drain_unit
    import store_drain_unit_pkg::*;
#(
    parameter int unsigned SDU_DEPTH          = SDU_DEPTH_DEFAULT,
    parameter int unsigned SDU_TIMEOUT_CYCLES = SDU_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_vld_i,
    input  sdq_entry_t  issue_entry_i,
    output logic        issue_en_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rsp_vld_i,
    input  logic        mem_err_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam int unsigned CW = $clog2(SDU_DEPTH) + 1;

    if ((SDU_DEPTH < 2) || ((SDU_DEPTH & (SDU_DEPTH - 1)) != 0) ||
        (SDU_TIMEOUT_CYCLES < 1)) begin : g_bad_param
        $error("store_drain_unit: invalid SDU_DEPTH or SDU_TIMEOUT_CYCLES");
    end

    sdu_state_t      r_state;
    sdu_state_t      w_state_nxt;
    logic            r_err;
    logic            w_err_set;
    logic            w_pop;
    logic            w_timeout;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    sdq_entry_t      w_head;
    logic            w_in_req;

    sdu_fifo #(
        .DEPTH (SDU_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (issue_vld_i),
        .data_i  (issue_entry_i),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

`ifdef SDU_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(SDU_TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] r_wdog;

    // Counts cycles spent in WAIT_RSP; restarts whenever the state is left.
    always_ff @(posedge clk_i) begin
        if (!rst_i || (r_state != WAIT_RSP) || (w_state_nxt != WAIT_RSP)) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_timeout = (r_state == WAIT_RSP) &&
                       (r_wdog == WDW'(SDU_TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        // A store arriving while full is dropped by the FIFO.
        w_err_set   = issue_vld_i && w_full;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    w_state_nxt = WAIT_RSP;
                    if (sdu_misaligned(w_head.addr[1:0])) begin
                        w_err_set = 1'b1;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_vld_i) begin
                    w_pop       = 1'b1;
                    w_state_nxt = IDLE;
                    if (mem_err_i) begin
                        w_err_set = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_pop       = 1'b1;
                    w_err_set   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are qualified with rst_i so they read zero throughout reset,
    // including the cycles before the first reset edge.
    assign w_in_req    = rst_i && (r_state == REQ);
    assign mem_req_o   = w_in_req;
    assign mem_addr_o  = w_in_req ? {w_head.addr[31:2], 2'b00} : '0;
    assign mem_wdata_o = w_in_req ? w_head.store_data : '0;
    assign issue_en_o  = rst_i && (w_count <= CW'(SDU_DEPTH - 2));
    assign busy_o      = rst_i && (!w_empty || (r_state != IDLE));
    assign err_o       = rst_i && r_err;

endmodule
